// File: rtl/cpu_pkg.sv
// Shared core constants, pc_src encoding and the IF/ID bundle.
// Used by if_stage and its next-PC mux.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pc_src_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // PC[31] is the supervisor bit; only the low 31 bits count.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction ROM bus and IF/ID register outputs of the fetch stage.
// master = if_stage, slave = ROM / decode side.
interface if_stage_if;

  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    output rom_addr,
    input  rom_data,
    output ifid_instr,
    output ifid_pc_plus4,
    output ifid_valid
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ifid_instr,
    input  ifid_pc_plus4,
    input  ifid_valid
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux with supervisor-bit rules.
// Priority: exc > pc_src redirect > irq > sequential.
import cpu_pkg::*;

module pc_next_sel (
  input  logic [31:0] pc,
  input  logic [3:0]  ifid_hi,
  input  pc_src_e     pc_src,
  input  logic        exc,
  input  logic        irq_accept,
  input  logic [30:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] tgt;
  logic        kern;

  assign kern = ifid_hi[3];

  always_comb begin
    tgt = pc_inc(pc);
    unique case (1'b1)
      pc_src == PC_BR:
        tgt = {kern, branch_target};
      pc_src == PC_J:
        tgt = {ifid_hi, jump_index, 2'b00};
      pc_src == PC_JR:
        // user code may never jump into kernel space
        tgt = kern ? jr_target
                   : {1'b0, jr_target[30:0]};
      default: ;
    endcase
  end

  always_comb begin
    next_pc  = pc_inc(pc);
    redirect = exc | irq_accept
             | (pc_src != PC_SEQ);
    unique case (1'b1)
      exc:
        next_pc = EXC_VEC;
      !exc && pc_src != PC_SEQ:
        next_pc = tgt;
      !exc && pc_src == PC_SEQ && irq_accept:
        next_pc = IRQ_VEC;
      default: ;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, ROM address, IF/ID register.
// Interrupt path present only when IF_IRQ_EN is defined.
import cpu_pkg::*;

module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic        exc,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        irq,
  if_stage_if.master  bus,
  output logic        irq_take,
  output logic [31:0] irq_epc
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        irq_accept;
  if_id_t      ifid;
  logic        unused_bits;

  assign pc_plus4    = pc_inc(pc);
  assign unused_bits = branch_target[31];

  assign bus.rom_addr      = pc;
  assign bus.ifid_instr    = ifid.instr;
  assign bus.ifid_pc_plus4 = ifid.pc_plus4;
  assign bus.ifid_valid    = ifid.valid;

`ifdef IF_IRQ_EN
  logic        take_q;
  logic [31:0] epc_q;

  assign irq_accept = irq & ~pc[31] & ~stall
                    & ~exc & ifid.valid
                    & (pc_src == PC_SEQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      take_q <= 1'b0;
      epc_q  <= '0;
    end else begin
      take_q <= irq_accept;
      if (irq_accept) epc_q <= pc_plus4;
    end
  end

  assign irq_take = take_q;
  assign irq_epc  = epc_q;
`else
  logic unused_irq;

  assign unused_irq = irq;
  assign irq_accept = 1'b0;
  assign irq_take   = 1'b0;
  assign irq_epc    = '0;
`endif

  pc_next_sel u_sel (
    .pc            (pc),
    .ifid_hi       (ifid.pc_plus4[31:28]),
    .pc_src        (pc_src_e'(pc_src)),
    .exc           (exc),
    .irq_accept    (irq_accept),
    .branch_target (branch_target[30:0]),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // redirects and flush both override a hazard stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pc <= RESET_PC;
    else if (redirect | flush | ~stall)
      pc <= next_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid <= '0;
    end else if (flush | irq_accept) begin
      ifid <= '{instr: NOP, pc_plus4: '0,
                valid: 1'b0};
    end else if (!stall) begin
      ifid <= '{instr: bus.rom_data,
                pc_plus4: pc_plus4,
                valid: 1'b1};
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table plus
// randomized traffic against a behavioural fetch-stage model.
module tb_if_stage;
  import cpu_pkg::*;

`ifdef IF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic        exc = 1'b0;
  logic [31:0] branch_target = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] jr_target = '0;
  logic        irq = 1'b0;
  logic        irq_take;
  logic [31:0] irq_epc;

  if_stage_if bus ();

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_src        (pc_src),
    .exc           (exc),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .irq           (irq),
    .bus           (bus),
    .irq_take      (irq_take),
    .irq_epc       (irq_epc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0800_0003;
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pp4, m_epc;
  logic        m_valid, m_take;

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_instr = '0; m_pp4 = '0;
    m_valid = 1'b0; m_take = 1'b0; m_epc = '0;
  endtask

  task automatic model_step();
    logic [31:0] seq, tgt, npc;
    logic        acc, redir, hold_pc;
    seq = {m_pc[31], m_pc[30:0] + 31'd4};
    case (pc_src)
      2'd1: tgt = {m_pp4[31], branch_target[30:0]};
      2'd2: tgt = {m_pp4[31:28], jump_index, 2'b00};
      2'd3: tgt = m_pp4[31] ? jr_target : {1'b0, jr_target[30:0]};
      default: tgt = seq;
    endcase
    acc = IRQ_EN && irq && !m_pc[31] && !stall && !exc
          && pc_src == 2'd0 && m_valid;
    if (exc) npc = 32'h8000_0008;
    else if (pc_src != 2'd0) npc = tgt;
    else if (acc) npc = 32'h8000_0004;
    else npc = seq;
    redir = exc || pc_src != 2'd0 || acc;
    hold_pc = stall && !redir && !flush;
    if (flush || acc) begin
      m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = rom_word(m_pc); m_pp4 = seq; m_valid = 1'b1;
    end
    if (acc) m_epc = seq;
    m_take = acc;
    if (!hold_pc) m_pc = npc;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".m_pc"},    bus.rom_addr,      m_pc);
    chk({tag, ".m_instr"}, bus.ifid_instr,    m_instr);
    chk({tag, ".m_pp4"},   bus.ifid_pc_plus4, m_pp4);
    chk({tag, ".m_valid"}, 32'(bus.ifid_valid), 32'(m_valid));
    chk({tag, ".m_take"},  32'(irq_take),     32'(m_take));
    if (m_take) chk({tag, ".m_epc"}, irq_epc, m_epc);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".pc"},    bus.rom_addr,      32'h8000_0000);
    chk({tag, ".instr"}, bus.ifid_instr,    32'h0);
    chk({tag, ".pp4"},   bus.ifid_pc_plus4, 32'h0);
    chk({tag, ".valid"}, 32'(bus.ifid_valid), 32'h0);
    chk({tag, ".take"},  32'(irq_take),     32'h0);
    chk({tag, ".epc"},   irq_epc,           32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_state(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          st, fl, ex, iq;
    logic [1:0]  src;
    logic [31:0] t;
    logic [25:0] j;
    logic [31:0] e_pc, e_pp4, e_instr, e_epc;
    bit          e_valid, e_take;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit st, bit fl, logic [1:0] src,
      bit ex, bit iq, logic [31:0] t, logic [25:0] j,
      logic [31:0] e_pc, logic [31:0] e_pp4, bit e_valid,
      logic [31:0] e_instr, bit e_take, logic [31:0] e_epc);
    vec_t v;
    v.st = st; v.fl = fl; v.src = src; v.ex = ex; v.iq = iq;
    v.t = t; v.j = j; v.e_pc = e_pc; v.e_pp4 = e_pp4;
    v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_take = e_take; v.e_epc = e_epc;
    return v;
  endfunction

  function automatic logic [31:0] sel(bit c, logic [31:0] a,
                                      logic [31:0] b);
    return c ? a : b;
  endfunction

  task automatic fill_table();
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h8000_0004, 32'h8000_0004, 1, 32'h0800_0003, 0, 0));
    tv.push_back(mk(0,1,3,0,0, 32'h100, 0,
      32'h100, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(1,0,0,0,0, 0, 0,
        32'h100, 0, 0, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h104, 32'h104, 1, rom_word(32'h100), 0, 0));
    tv.push_back(mk(0,1,2,0,0, 0, 26'h43,
      32'h10C, 0, 0, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h110, 32'h110, 1, rom_word(32'h10C), 0, 0));
    tv.push_back(mk(0,1,3,0,0, 32'hFC, 0,
      32'hFC, 0, 0, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h100, 32'h100, 1, rom_word(32'hFC), 0, 0));
    tv.push_back(mk(0,0,0,0,1, 0, 0,
      sel(IRQ_EN, 32'h8000_0004, 32'h104),
      sel(IRQ_EN, 32'h0, 32'h104), !IRQ_EN,
      sel(IRQ_EN, 32'h0, rom_word(32'h100)), IRQ_EN, 32'h104));
    tv.push_back(mk(0,1,3,0,0, 32'h8000_0040, 0,
      32'h40, 0, 0, 0, 0, 0));
    tv.push_back(mk(1,0,0,1,0, 0, 0,
      32'h8000_0008, 0, 0, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h8000_000C, 32'h8000_000C, 1, rom_word(32'h8000_0008), 0, 0));
    tv.push_back(mk(0,0,0,0,1, 0, 0,
      32'h8000_0010, 32'h8000_0010, 1, rom_word(32'h8000_000C), 0, 0));
    tv.push_back(mk(0,1,3,0,0, 32'h150, 0,
      32'h150, 0, 0, 0, 0, 0));
    tv.push_back(mk(1,1,1,0,0, 32'h200, 0,
      32'h200, 0, 0, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h204, 32'h204, 1, rom_word(32'h200), 0, 0));
    tv.push_back(mk(0,1,1,0,0, 32'h8000_0300, 0,
      32'h300, 0, 0, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      32'h304, 32'h304, 1, rom_word(32'h300), 0, 0));
    tv.push_back(mk(1,0,0,0,1, 0, 0,
      32'h304, 32'h304, 1, rom_word(32'h300), 0, 0));
    tv.push_back(mk(0,0,0,0,1, 0, 0,
      sel(IRQ_EN, 32'h8000_0004, 32'h308),
      sel(IRQ_EN, 32'h0, 32'h308), !IRQ_EN,
      sel(IRQ_EN, 32'h0, rom_word(32'h304)), IRQ_EN, 32'h308));
    tv.push_back(mk(0,0,0,0,0, 0, 0,
      sel(IRQ_EN, 32'h8000_0008, 32'h30C),
      sel(IRQ_EN, 32'h8000_0008, 32'h30C), 1,
      sel(IRQ_EN, rom_word(32'h8000_0004), rom_word(32'h308)), 0, 0));
  endtask

  task automatic drive_vec(input vec_t v);
    stall = v.st; flush = v.fl; pc_src = v.src;
    exc = v.ex; irq = v.iq;
    branch_target = v.t; jr_target = v.t; jump_index = v.j;
  endtask

  initial begin
    string tag;
    model_reset();
    fill_table();
    #2 reset = 1'b0;
    #3;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (tv[i]) begin
      drive_vec(tv[i]);
      model_step();
      @(posedge clk); #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, ".pc"},    bus.rom_addr,      tv[i].e_pc);
      chk({tag, ".pp4"},   bus.ifid_pc_plus4, tv[i].e_pp4);
      chk({tag, ".valid"}, 32'(bus.ifid_valid), 32'(tv[i].e_valid));
      chk({tag, ".instr"}, bus.ifid_instr,    tv[i].e_instr);
      chk({tag, ".take"},  32'(irq_take),     32'(tv[i].e_take));
      if (tv[i].e_take) chk({tag, ".epc"}, irq_epc, tv[i].e_epc);
      check_model(tag);
    end

    // mid-flight asynchronous reset
    drive_vec(mk(0,0,0,0,0, 0,0, 0,0,0,0,0,0));
    do_reset("midreset");

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($sformatf("rreset%0d", c));
        continue;
      end
      stall  = ($urandom_range(0, 4) == 0);
      pc_src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                           : 2'd0;
      exc    = ($urandom_range(0, 19) == 0);
      flush  = (pc_src != 2'd0 || exc) ? 1'b1
                                       : ($urandom_range(0, 9) == 0);
      irq    = ($urandom_range(0, 2) == 0);
      branch_target = $urandom;
      jr_target     = $urandom;
      jump_index    = 26'($urandom);
      model_step();
      @(posedge clk); #1;
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the instruction ROM address, and captures the returned word into the IF/ID pipeline register. Selects the next PC from sequential, branch, jump, register-jump, exception and interrupt sources, and enforces the PC[31] supervisor bit. It sits directly upstream of the instruction ROM and feeds the decode stage.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset; kernel mode.
- IRQ_VEC, 32'h8000_0004, interrupt handler entry.
- EXC_VEC, 32'h8000_0008, illegal-instruction handler entry.

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  write NOP into IF/ID this edge
- pc_src  in  2  0 sequential, 1 branch, 2 jump, 3 jr
- exc  in  1  illegal instruction in ID; redirect to EXC_VEC
- branch_target  in  32  branch address computed in ID
- jump_index  in  26  instr[25:0] of jump in ID
- jr_target  in  32  forwarded rs value for jr/jalr
- irq  in  1  level interrupt request from peripherals
- rom_addr  out  32  equals current PC (combinational)
- rom_data  in  32  instruction word for rom_addr
- ifid_instr  out  32  registered instruction
- ifid_pc_plus4  out  32  registered PC+4 of that instruction
- ifid_valid  out  1  0 when IF/ID holds a bubble
- irq_take  out  1  one-cycle pulse when interrupt accepted
- irq_epc  out  32  return value for $k0, valid with irq_take

## Operation
- PC+4: PC[30:0] increments modulo 2^31; PC[31] is preserved.
- Next-PC priority: exc > pc_src != 0 > irq > sequential.
- Branch: {ifid_pc_plus4[31], branch_target[30:0]}.
- Jump: {ifid_pc_plus4[31:28], jump_index, 2'b00}.
- jr: if ifid_pc_plus4[31]=1, full jr_target (may drop to user mode); if 0, {1'b0, jr_target[30:0]} (user code cannot enter kernel).
- exc: PC <= EXC_VEC, irrespective of stall.
- irq accepted only when irq=1, PC[31]=0, stall=0, exc=0, pc_src=0, ifid_valid=1. On accept: PC <= IRQ_VEC, IF/ID <= NOP, irq_take=1, irq_epc = PC+4 (handler subtracts 4 and resumes at the squashed instruction).
- irq is ignored in kernel mode; no latching; a level still high on return to user mode is taken then.
- stall=1 with no redirect: PC, ifid_* unchanged.
- flush=1: ifid_instr <= 0, ifid_valid <= 0, ifid_pc_plus4 <= 0; PC takes selected redirect. flush overrides stall for both PC and IF/ID.
- Normal: ifid_instr <= rom_data, ifid_pc_plus4 <= PC+4, ifid_valid <= 1.

## Timing
- Reset (async, reset=0): PC=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, irq_take=0, irq_epc=0.
- rom_addr follows PC combinationally; ROM read is combinational, instruction lands in IF/ID one edge after PC is presented.
- Redirect from ID is visible on rom_addr the cycle after the edge; one-slot penalty (caller asserts flush).
- irq_take is registered; high exactly one cycle after the accept edge. Reset mid-handler returns to RESET_PC with no pending state.

## Configuration
- IF_IRQ_EN defined: interrupt path as above.
- Undefined: irq ignored, irq_take and irq_epc tied to 0; all other behaviour identical.

## Structure
- Shared package cpu_pkg: RESET_PC/IRQ_VEC/EXC_VEC constants, pc_src encoding (PC_SEQ, PC_BR, PC_J, PC_JR), NOP constant.
- One sub-module: pc_next_sel (combinational next-PC mux incl. supervisor-bit rule); registers stay in if_stage.

## Test plan
- Release reset with ROM word 0 = 32'h0800_0003 -> rom_addr 32'h8000_0000, then 32'h8000_0004; ifid_instr 32'h0800_0003, ifid_pc_plus4 32'h8000_0004, ifid_valid 1.
- stall=1 for 3 cycles at PC 32'h0000_0100 -> rom_addr and ifid_* constant; releases to 32'h0000_0104.
- pc_src=2, jump_index 26'h43, ifid_pc_plus4 32'h0000_0110, flush=1 -> PC 32'h0000_010C, ifid_instr 0, ifid_valid 0.
- irq=1 at user PC 32'h0000_0100 -> PC 32'h8000_0004, irq_take pulse, irq_epc 32'h0000_0104, IF/ID bubble; irq=1 at PC 32'h8000_0050 -> no effect.
- jr: user mode target 32'h8000_0040 -> PC 32'h0000_0040; kernel mode target 32'h0000_0150 -> PC 32'h0000_0150.
- Simultaneous stall+flush+pc_src=1 (target 32'h0000_0200) -> PC 32'h0000_0200, IF/ID bubble; exc with stall -> PC 32'h8000_0008.
